// File: rtl/inst_fetch_queue.sv
// 4-wide instruction buffer between I-fetch and the 4-slot decoder.
// Circular DEPTH-entry store; the four oldest entries are presented combinationally from registered state.
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          fetch_valid,
  input  logic [2:0]    fetch_cnt,
  input  logic [31:0]   fetch_inst1,
  input  logic [31:0]   fetch_inst2,
  input  logic [31:0]   fetch_inst3,
  input  logic [31:0]   fetch_inst4,
  output logic          fetch_ready,
  input  logic [2:0]    dec_take,
  output logic          inst_en,
  output logic [31:0]   Inst1,
  output logic [31:0]   Inst2,
  output logic [31:0]   Inst3,
  output logic [31:0]   Inst4,
  output logic [3:0]    inst_valid,
  output logic [AW:0]   count
);

  localparam int unsigned CW     = AW + 1;
  localparam int unsigned BUNDLE = 4;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - BUNDLE);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [2:0]    wr_cnt;
  logic [2:0]    take;
  logic          wr_en;
  logic [31:0]   fetch_data [BUNDLE];
  logic [31:0]   rd_data [BUNDLE];

  // Accept only when a full bundle fits in the registered free space.
  assign fetch_ready = (count_q <= READY_MAX);

  // Clamp oversize requests: bundle to 4, take to current occupancy.
  always_comb begin
    wr_cnt = (fetch_cnt > 3'd4) ? 3'd4 : fetch_cnt;
    take   = (CW'(dec_take) > count_q) ? count_q[2:0] : dec_take;
    wr_en  = fetch_valid && fetch_ready && !flush && !rst;
    fetch_data[0] = fetch_inst1;
    fetch_data[1] = fetch_inst2;
    fetch_data[2] = fetch_inst3;
    fetch_data[3] = fetch_inst4;
  end

  // Pointer and occupancy next-state; flush wins over write and take.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(take);
      count_d = count_q - CW'(take);
      if (wr_en) begin
        tail_d  = tail_q + AW'(wr_cnt);
        count_d = count_d + CW'(wr_cnt);
      end
    end
  end

  // Bundle slots land at consecutive entries from tail, wrapping modulo DEPTH.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      for (int j = 0; j < int'(BUNDLE); j++) begin
        if (3'(j) < wr_cnt) begin
          mem_d[tail_q + AW'(j)] = fetch_data[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not cleared by reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Head window: slot k shows entry head+k when occupied, else a zero NOP.
  always_comb begin
    inst_valid = '0;
    for (int k = 0; k < int'(BUNDLE); k++) begin
      inst_valid[k] = (count_q > CW'(k));
      rd_data[k]    = inst_valid[k] ? mem_q[head_q + AW'(k)] : 32'h0;
    end
  end

  assign Inst1   = rd_data[0];
  assign Inst2   = rd_data[1];
  assign Inst3   = rd_data[2];
  assign Inst4   = rd_data[3];
  assign inst_en = (count_q != '0);
  assign count   = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed vector table, wrap-around sequence,
// and randomized traffic against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic        clk = 1'b0;
  logic        rst, flush, fetch_valid;
  logic [2:0]  fetch_cnt, dec_take;
  logic [31:0] fetch_inst1, fetch_inst2, fetch_inst3, fetch_inst4;
  logic        fetch_ready, inst_en;
  logic [31:0] Inst1, Inst2, Inst3, Inst4;
  logic [3:0]  inst_valid;
  logic [AW:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mq [$];

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_cnt(fetch_cnt),
    .fetch_inst1(fetch_inst1), .fetch_inst2(fetch_inst2),
    .fetch_inst3(fetch_inst3), .fetch_inst4(fetch_inst4),
    .fetch_ready(fetch_ready), .dec_take(dec_take),
    .inst_en(inst_en), .Inst1(Inst1), .Inst2(Inst2), .Inst3(Inst3), .Inst4(Inst4),
    .inst_valid(inst_valid), .count(count)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        fv;
    logic [2:0]  fcnt;
    logic [2:0]  take;
    logic [31:0] base;
    int          e_count;
    logic        e_ready;
    logic        e_en;
    logic [3:0]  e_valid;
    logic [31:0] e_inst1;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: FIFO of instructions; pop min(take,size) then append the accepted bundle.
  task automatic model_edge();
    int sz, tk, n;
    logic [31:0] b [4];
    sz = mq.size();
    if (rst || flush) begin
      mq.delete();
      return;
    end
    b[0] = fetch_inst1; b[1] = fetch_inst2; b[2] = fetch_inst3; b[3] = fetch_inst4;
    tk = (int'(dec_take) < sz) ? int'(dec_take) : sz;
    for (int i = 0; i < tk; i++) void'(mq.pop_front());
    if (fetch_valid && (DEPTH - sz >= 4)) begin
      n = (fetch_cnt > 3'd4) ? 4 : int'(fetch_cnt);
      for (int j = 0; j < n; j++) mq.push_back(b[j]);
    end
  endtask

  task automatic cycle(input logic r, input logic f, input logic fv, input logic [2:0] fc,
                       input logic [2:0] tk, input logic [31:0] i1, input logic [31:0] i2,
                       input logic [31:0] i3, input logic [31:0] i4);
    rst = r; flush = f; fetch_valid = fv; fetch_cnt = fc; dec_take = tk;
    fetch_inst1 = i1; fetch_inst2 = i2; fetch_inst3 = i3; fetch_inst4 = i4;
    if (!r && !f && int'(tk) > mq.size())
      $display("[TB] protocol violation flagged: dec_take=%0d exceeds count=%0d", tk, mq.size());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    int sz;
    logic [31:0] exp_inst;
    logic [31:0] act_inst [4];
    sz = mq.size();
    act_inst[0] = Inst1; act_inst[1] = Inst2; act_inst[2] = Inst3; act_inst[3] = Inst4;
    chk({tag, " count"}, 32'(count), 32'(sz));
    chk({tag, " fetch_ready"}, 32'(fetch_ready), 32'(DEPTH - sz >= 4));
    chk({tag, " inst_en"}, 32'(inst_en), 32'(sz != 0));
    for (int k = 0; k < 4; k++) begin
      exp_inst = (sz > k) ? mq[k] : 32'h0;
      chk({tag, " inst_valid"}, 32'(inst_valid[k]), 32'(sz > k));
      chk($sformatf("%s Inst%0d", tag, k + 1), act_inst[k], exp_inst);
    end
    chk({tag, " count<=DEPTH"}, 32'(int'(count) <= DEPTH), 32'd1);
  endtask

  vec_t vt [$];

  task automatic add(input logic r, input logic f, input logic fv, input logic [2:0] fc,
                     input logic [2:0] tk, input logic [31:0] base, input int ec,
                     input logic er, input logic een, input logic [3:0] ev, input logic [31:0] ei1);
    vec_t v;
    v.rst = r; v.flush = f; v.fv = fv; v.fcnt = fc; v.take = tk; v.base = base;
    v.e_count = ec; v.e_ready = er; v.e_en = een; v.e_valid = ev; v.e_inst1 = ei1;
    vt.push_back(v);
  endtask

  initial begin
    int sz, tk;
    logic [31:0] b;
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0; fetch_cnt = 3'd0; dec_take = 3'd0;
    fetch_inst1 = '0; fetch_inst2 = '0; fetch_inst3 = '0; fetch_inst4 = '0;

    //   rst f  fv cnt  tk  base           cnt rdy en valid    inst1
    add(1, 0, 0, 3'd0, 3'd0, 32'h0,         0, 1, 0, 4'b0000, 32'h0);
    add(0, 0, 0, 3'd0, 3'd0, 32'h0,         0, 1, 0, 4'b0000, 32'h0);
    add(0, 0, 1, 3'd4, 3'd0, 32'h1000_0000, 4, 1, 1, 4'b1111, 32'h1000_0000);
    add(0, 0, 1, 3'd4, 3'd0, 32'h1000_0004, 8, 1, 1, 4'b1111, 32'h1000_0000);
    add(0, 0, 1, 3'd4, 3'd0, 32'h1000_0008, 12, 1, 1, 4'b1111, 32'h1000_0000);
    add(0, 0, 1, 3'd4, 3'd0, 32'h1000_000C, 16, 0, 1, 4'b1111, 32'h1000_0000);
    add(0, 0, 0, 3'd0, 3'd4, 32'h0,         12, 1, 1, 4'b1111, 32'h1000_0004);
    add(0, 0, 0, 3'd0, 3'd4, 32'h0,         8, 1, 1, 4'b1111, 32'h1000_0008);
    add(0, 0, 0, 3'd0, 3'd4, 32'h0,         4, 1, 1, 4'b1111, 32'h1000_000C);
    add(0, 0, 0, 3'd0, 3'd4, 32'h0,         0, 1, 0, 4'b0000, 32'h0);
    add(0, 0, 1, 3'd3, 3'd0, 32'h2000_0000, 3, 1, 1, 4'b0111, 32'h2000_0000);
    add(0, 0, 1, 3'd2, 3'd1, 32'h2000_0003, 4, 1, 1, 4'b1111, 32'h2000_0001);
    add(0, 0, 1, 3'd4, 3'd0, 32'h3000_0000, 8, 1, 1, 4'b1111, 32'h2000_0001);
    add(0, 0, 1, 3'd1, 3'd0, 32'h3000_0004, 9, 1, 1, 4'b1111, 32'h2000_0001);
    add(0, 1, 1, 3'd4, 3'd2, 32'h4000_0000, 0, 1, 0, 4'b0000, 32'h0);
    add(0, 0, 1, 3'd4, 3'd0, 32'h5000_0000, 4, 1, 1, 4'b1111, 32'h5000_0000);
    add(0, 0, 1, 3'd4, 3'd0, 32'h5000_0004, 8, 1, 1, 4'b1111, 32'h5000_0000);
    add(0, 0, 1, 3'd4, 3'd0, 32'h5000_0008, 12, 1, 1, 4'b1111, 32'h5000_0000);
    add(0, 0, 1, 3'd1, 3'd0, 32'h5000_000C, 13, 0, 1, 4'b1111, 32'h5000_0000);
    add(0, 0, 1, 3'd4, 3'd0, 32'h6000_0000, 13, 0, 1, 4'b1111, 32'h5000_0000);
    add(0, 0, 0, 3'd0, 3'd1, 32'h0,         12, 1, 1, 4'b1111, 32'h5000_0001);
    add(0, 1, 0, 3'd0, 3'd0, 32'h0,         0, 1, 0, 4'b0000, 32'h0);
    add(0, 0, 1, 3'd2, 3'd0, 32'h7000_0000, 2, 1, 1, 4'b0011, 32'h7000_0000);
    add(0, 0, 0, 3'd0, 3'd4, 32'h0,         0, 1, 0, 4'b0000, 32'h0);
    add(0, 0, 1, 3'd7, 3'd0, 32'h7100_0000, 4, 1, 1, 4'b1111, 32'h7100_0000);
    add(1, 1, 1, 3'd4, 3'd0, 32'h7200_0000, 0, 1, 0, 4'b0000, 32'h0);

    foreach (vt[i]) begin
      cycle(vt[i].rst, vt[i].flush, vt[i].fv, vt[i].fcnt, vt[i].take,
            vt[i].base, vt[i].base + 32'd1, vt[i].base + 32'd2, vt[i].base + 32'd3);
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vt[i].e_count));
      chk($sformatf("vec%0d fetch_ready", i), 32'(fetch_ready), 32'(vt[i].e_ready));
      chk($sformatf("vec%0d inst_en", i), 32'(inst_en), 32'(vt[i].e_en));
      chk($sformatf("vec%0d inst_valid", i), 32'(inst_valid), 32'(vt[i].e_valid));
      chk($sformatf("vec%0d Inst1", i), Inst1, vt[i].e_inst1);
    end
    chk("vec_last Inst4 after oversize fetch_cnt", Inst4, 32'h0);

    // Wrap-around: walk head and tail to 14, then write a bundle straddling 15->0.
    cycle(1, 0, 0, 3'd0, 3'd0, 0, 0, 0, 0);
    cycle(0, 0, 1, 3'd1, 3'd0, 32'hEE00_0000, 0, 0, 0);
    for (int n = 1; n < 14; n++) cycle(0, 0, 1, 3'd1, 3'd1, 32'hEE00_0000 + 32'(n), 0, 0, 0);
    cycle(0, 0, 0, 3'd0, 3'd1, 0, 0, 0, 0);
    chk("wrap pre count", 32'(count), 32'd0);
    cycle(0, 0, 1, 3'd4, 3'd0, 32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D);
    chk("wrap Inst1", Inst1, 32'hA000_000A);
    chk("wrap Inst2", Inst2, 32'hB000_000B);
    chk("wrap Inst3", Inst3, 32'hC000_000C);
    chk("wrap Inst4", Inst4, 32'hD000_000D);
    chk("wrap count", 32'(count), 32'd4);
    cycle(0, 0, 0, 3'd0, 3'd2, 0, 0, 0, 0);
    chk("wrap post-take Inst1", Inst1, 32'hC000_000C);
    chk("wrap post-take Inst2", Inst2, 32'hD000_000D);
    chk("wrap post-take inst_valid", 32'(inst_valid), 32'h3);
    check_model("wrap");

    // Randomized traffic against the reference queue.
    for (int c = 0; c < 3000; c++) begin
      sz = mq.size();
      tk = (sz < 4) ? sz : 4;
      b  = $urandom;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, tk)), b, $urandom, $urandom, $urandom);
      check_model($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
